// File: rtl/ifu_swc_fetch.sv
// SwitchMCU instruction fetch unit: single-word AHB-Lite read master with
// cycle-counter/stall/ITCM gating and branch redirect with in-flight flush.
module ifu_swc_fetch (
   input  logic        hclk,
   input  logic        hrstn,
   input  logic        hready,
   input  logic        hresp,
   input  logic [31:0] hrdata,
   input  logic        itcm_ready,
   input  logic        ifu_dec_stall,
   input  logic [3:0]  cycle_cnt,
   input  logic        pc_write,
   input  logic [31:0] pc_wdata,
   output logic [31:0] haddr,
   output logic        hwrite,
   output logic [31:0] hwdata,
   output logic [2:0]  hsize,
   output logic [2:0]  hburst,
   output logic [6:0]  hprot,
   output logic [1:0]  htrans,
   output logic        hmastlock,
   output logic        ifu_idle,
   output logic [31:0] pc,
   output logic [31:0] inst_out
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2
   } state_t;

   localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
   localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
   localparam logic [31:0] NOP_INST      = 32'h0000_0013;

   state_t      state_q, state_d;
   logic        flush_q, flush_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] haddr_q, haddr_d;
   logic [1:0]  htrans_q, htrans_d;
   logic        idle_q, idle_d;
   logic [31:0] inst_q, inst_d;

   logic start_ok;
   assign start_ok = (cycle_cnt == 4'd0) && !ifu_dec_stall && itcm_ready && !pc_write;

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
      state_d  = state_q;
      flush_d  = flush_q;
      pc_d     = pc_q;
      haddr_d  = haddr_q;
      htrans_d = htrans_q;
      idle_d   = idle_q;
      inst_d   = inst_q;

      case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               state_d  = S_ADDR;
               haddr_d  = pc_q;
               htrans_d = HTRANS_NONSEQ;
               idle_d   = 1'b0;
            end
         end
         S_ADDR: begin
            if (hready) begin
               state_d  = S_DATA;
               htrans_d = HTRANS_IDLE;
            end
         end
         S_DATA: begin
            if (hready) begin
               state_d = S_IDLE;
               idle_d  = 1'b1;
               flush_d = 1'b0;
               if (!flush_q && !pc_write) begin
                  if (hresp) begin
                     inst_d = NOP_INST;
                  end else begin
                     inst_d = hrdata;
                     pc_d   = pc_q + 32'd4;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Redirect wins over everything; an unfinished transfer is marked so its data is dropped.
      if (pc_write) begin
         pc_d = {pc_wdata[31:2], 2'b00};
         if ((state_q == S_ADDR) || (state_q == S_DATA && !hready))
            flush_d = 1'b1;
      end
   end

   always_ff @(posedge hclk) begin
      // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
      if (hrstn) begin
         state_q  <= S_IDLE;
         flush_q  <= 1'b0;
         pc_q     <= 32'h0;
         haddr_q  <= 32'h0;
         htrans_q <= HTRANS_IDLE;
         idle_q   <= 1'b1;
         inst_q   <= NOP_INST;
      end else begin
         state_q  <= state_d;
         flush_q  <= flush_d;
         pc_q     <= pc_d;
         haddr_q  <= haddr_d;
         htrans_q <= htrans_d;
         idle_q   <= idle_d;
         inst_q   <= inst_d;
      end
   end

   assign haddr     = haddr_q;
   assign htrans    = htrans_q;
   assign ifu_idle  = idle_q;
   assign pc        = pc_q;
   assign inst_out  = inst_q;
   assign hwrite    = 1'b0;
   assign hwdata    = 32'h0;
   assign hsize     = 3'b010;
   assign hburst    = 3'b000;
   assign hprot     = 7'b0000010;
   assign hmastlock = 1'b0;

endmodule

// File: tb/tb_ifu_swc_fetch.sv
// Directed bench for ifu_swc_fetch: reset, gating, wait states, redirect,
// error response, PC wrap and reset mid-transfer, with hand-computed expectations.
module tb_ifu_swc_fetch;

   logic        hclk = 1'b0;
   logic        hrstn, hready, hresp, itcm_ready, ifu_dec_stall, pc_write;
   logic [31:0] hrdata, pc_wdata;
   logic [3:0]  cycle_cnt;
   logic [31:0] haddr, hwdata, pc, inst_out;
   logic        hwrite, hmastlock, ifu_idle;
   logic [2:0]  hsize, hburst;
   logic [6:0]  hprot;
   logic [1:0]  htrans;

   int vectors = 0;
   int miscompares = 0;

   always #5 hclk = ~hclk;

   ifu_swc_fetch dut (
      .hclk(hclk), .hrstn(hrstn), .hready(hready), .hresp(hresp), .hrdata(hrdata),
      .itcm_ready(itcm_ready), .ifu_dec_stall(ifu_dec_stall), .cycle_cnt(cycle_cnt),
      .pc_write(pc_write), .pc_wdata(pc_wdata), .haddr(haddr), .hwrite(hwrite),
      .hwdata(hwdata), .hsize(hsize), .hburst(hburst), .hprot(hprot), .htrans(htrans),
      .hmastlock(hmastlock), .ifu_idle(ifu_idle), .pc(pc), .inst_out(inst_out)
   );

   task automatic step();
      @(posedge hclk);
      #2;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      hrstn = 1'b1; hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
      itcm_ready = 1'b1; ifu_dec_stall = 1'b0; cycle_cnt = 4'd5;
      pc_write = 1'b0; pc_wdata = 32'h0;

      // Reset
      step(); step();
      check("rst_pc", pc, 32'h0);
      check("rst_htrans", {30'b0, htrans}, 32'h0);
      check("rst_idle", {31'b0, ifu_idle}, 32'h1);
      check("rst_inst", inst_out, 32'h13);
      check("rst_haddr", haddr, 32'h0);
      check("hsize", {29'b0, hsize}, 32'h2);
      check("hprot", {25'b0, hprot}, 32'h2);
      check("hburst", {29'b0, hburst}, 32'h0);
      check("hwrite_lock", {30'b0, hwrite, hmastlock}, 32'h0);
      check("hwdata", hwdata, 32'h0);
      hrstn = 1'b0;
      step();
      check("no_start_cnt5", {30'b0, htrans}, 32'h0);

      // Zero-wait fetch
      cycle_cnt = 4'd0; hrdata = 32'hDEADBEEF;
      step();
      check("zw_t0_htrans", {30'b0, htrans}, 32'h2);
      check("zw_t0_haddr", haddr, 32'h0);
      check("zw_t0_idle", {31'b0, ifu_idle}, 32'h0);
      cycle_cnt = 4'd5;
      step();
      check("zw_t1_htrans", {30'b0, htrans}, 32'h0);
      check("zw_t1_inst", inst_out, 32'h13);
      step();
      check("zw_t2_inst", inst_out, 32'hDEADBEEF);
      check("zw_t2_pc", pc, 32'h4);
      check("zw_t2_idle", {31'b0, ifu_idle}, 32'h1);

      // Gating
      cycle_cnt = 4'd3;
      step();
      check("gate_cnt_htrans", {30'b0, htrans}, 32'h0);
      cycle_cnt = 4'd0; ifu_dec_stall = 1'b1;
      step();
      check("gate_stall_htrans", {30'b0, htrans}, 32'h0);
      ifu_dec_stall = 1'b0; itcm_ready = 1'b0;
      step();
      check("gate_itcm_htrans", {30'b0, htrans}, 32'h0);
      check("gate_pc", pc, 32'h4);
      itcm_ready = 1'b1;
      step();
      check("release_htrans", {30'b0, htrans}, 32'h2);
      check("release_haddr", haddr, 32'h4);

      // Wait states in the data phase
      cycle_cnt = 4'd5;
      step();
      check("ws_data_htrans", {30'b0, htrans}, 32'h0);
      hready = 1'b0; hrdata = 32'hCAFEF00D;
      for (int i = 0; i < 3; i++) begin
         step();
         check("ws_hold_inst", inst_out, 32'hDEADBEEF);
         check("ws_hold_idle", {31'b0, ifu_idle}, 32'h0);
         check("ws_hold_htrans", {30'b0, htrans}, 32'h0);
      end
      hready = 1'b1;
      step();
      check("ws_done_inst", inst_out, 32'hCAFEF00D);
      check("ws_done_pc", pc, 32'h8);

      // Redirect during the address phase
      cycle_cnt = 4'd0;
      step();
      check("rd_start_haddr", haddr, 32'h8);
      cycle_cnt = 4'd5; pc_write = 1'b1; pc_wdata = 32'h103;
      step();
      check("rd_pc", pc, 32'h100);
      check("rd_htrans", {30'b0, htrans}, 32'h0);
      pc_write = 1'b0; hrdata = 32'h11111111;
      step();
      check("rd_discard_inst", inst_out, 32'hCAFEF00D);
      check("rd_discard_pc", pc, 32'h100);
      check("rd_discard_idle", {31'b0, ifu_idle}, 32'h1);
      cycle_cnt = 4'd0;
      step();
      check("rd_next_haddr", haddr, 32'h100);
      check("rd_next_htrans", {30'b0, htrans}, 32'h2);

      // Error response
      cycle_cnt = 4'd5;
      step();
      hresp = 1'b1;
      step();
      check("err_inst", inst_out, 32'h13);
      check("err_pc", pc, 32'h100);
      hresp = 1'b0; cycle_cnt = 4'd0;
      step();
      check("err_refetch_haddr", haddr, 32'h100);
      cycle_cnt = 4'd5; hrdata = 32'h12345678;
      step(); step();
      check("refetch_inst", inst_out, 32'h12345678);
      check("refetch_pc", pc, 32'h104);

      // Redirect in IDLE blocks a start; PC wraps at the top
      cycle_cnt = 4'd0; pc_write = 1'b1; pc_wdata = 32'hFFFFFFFF;
      step();
      check("wrap_redirect_pc", pc, 32'hFFFFFFFC);
      check("wrap_redirect_nostart", {30'b0, htrans}, 32'h0);
      pc_write = 1'b0;
      step();
      check("wrap_haddr", haddr, 32'hFFFFFFFC);
      cycle_cnt = 4'd5; hrdata = 32'hA5A5A5A5;
      step(); step();
      check("wrap_pc", pc, 32'h0);
      check("wrap_inst", inst_out, 32'hA5A5A5A5);

      // Redirect in the same cycle as completion
      cycle_cnt = 4'd0;
      step();
      cycle_cnt = 4'd5;
      step();
      pc_write = 1'b1; pc_wdata = 32'h200; hrdata = 32'h77;
      step();
      check("rdc_pc", pc, 32'h200);
      check("rdc_inst", inst_out, 32'hA5A5A5A5);
      check("rdc_idle", {31'b0, ifu_idle}, 32'h1);
      pc_write = 1'b0; cycle_cnt = 4'd0;
      step();
      check("rdc_next_haddr", haddr, 32'h200);
      cycle_cnt = 4'd5; hrdata = 32'h99;
      step(); step();
      check("rdc_flush_clear_inst", inst_out, 32'h99);
      check("rdc_flush_clear_pc", pc, 32'h204);

      // Reset mid-transfer
      cycle_cnt = 4'd0;
      step();
      check("mid_start", {30'b0, htrans}, 32'h2);
      hrstn = 1'b1;
      step();
      check("mid_rst_pc", pc, 32'h0);
      check("mid_rst_htrans", {30'b0, htrans}, 32'h0);
      check("mid_rst_idle", {31'b0, ifu_idle}, 32'h1);
      check("mid_rst_inst", inst_out, 32'h13);
      check("mid_rst_haddr", haddr, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
